// File: rtl/conv1d_sequencer_if.sv
// Bundles the control, status and buffer-read signals of conv1d_sequencer.
// Latency: none, this is wiring only.
// Backpressure: none; the buffers are assumed to answer every read one cycle later.
//
// Modports:
//   slave  - the sequencer: takes start/abort/config and read data, drives the
//            read strobe, the addresses and the status outputs.
//   master - the host/buffer side, which is the mirror image of slave.
interface conv1d_sequencer_if #(
    parameter int ADDR_W = 10
);
    // control and configuration
    logic              start;
    logic              abort;
    logic [31:0]       start_x;
    logic [31:0]       input_depth;
    logic [31:0]       input_offset;

    // buffer read port, one-cycle read latency
    logic              rd_en;
    logic [ADDR_W-1:0] in_rd_addr;
    logic [ADDR_W-1:0] flt_rd_addr;
    logic [63:0]       in_rd_data;
    logic [63:0]       flt_rd_data;

    // status
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       acc;
    logic [31:0]       busy_cycles;

    modport master (
        output start, abort, start_x, input_depth, input_offset,
        output in_rd_data, flt_rd_data,
        input  rd_en, in_rd_addr, flt_rd_addr,
        input  busy, done, err, acc, busy_cycles
    );

    modport slave (
        input  start, abort, start_x, input_depth, input_offset,
        input  in_rd_data, flt_rd_data,
        output rd_en, in_rd_addr, flt_rd_addr,
        output busy, done, err, acc, busy_cycles
    );
endinterface

// File: rtl/conv1d_sequencer.sv
// Streams one 1-D convolution tap (input ring buffer x filter) through an 8-lane MAC.
// Latency: start -> done is input_depth+2 cycles; a rejected start pulses done 1 cycle later.
// Backpressure: none; one read beat per cycle, reads assumed to return exactly 1 cycle later.
//
// Ports:
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   bus (slave)  - start/abort and configuration in, buffer read port
//                  (rd_en, in/flt address out, in/flt data in), busy/done/err/acc/busy_cycles out
//
// Optional feature: define CONV1D_SEQ_PERF_CNT_EN to build the saturating busy-cycle
// counter; without it busy_cycles is tied to zero.
module conv1d_sequencer #(
    parameter int ADDR_W    = 10,
    parameter int MAX_DEPTH = 128
) (
    input  logic                clk,
    input  logic                reset,
    conv1d_sequencer_if.slave   bus
);

    localparam logic [31:0] MAX_DEPTH_W = 32'(MAX_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t      state;
    logic [31:0] depth_q;       // channel count of the current run
    logic [31:0] offset_q;      // offset added to every input byte
    logic [31:0] beat_cnt;      // beats issued so far, including the one on the bus now
    logic        data_vld;      // read data on the bus belongs to a beat issued last cycle

    // ------------------------------------------------------------------
    // Start qualification
    // ------------------------------------------------------------------
    logic start_req;
    logic cfg_ok;

    // abort wins over a simultaneous start
    assign start_req = (state == ST_IDLE) && bus.start && !bus.abort;

    assign cfg_ok = (bus.input_depth != 32'd0)
                 && (bus.input_depth[2:0] == 3'b000)
                 && (bus.input_depth <= MAX_DEPTH_W)
                 && (bus.start_x <= 32'd7);

    // First input address of the run. start_x only seeds this value, so it is
    // consumed on the accepting edge rather than kept for the rest of the run.
    // A legal configuration keeps the product inside the buffer.
    logic [ADDR_W-1:0] base_addr;
    assign base_addr = ADDR_W'(bus.start_x[2:0]) * bus.input_depth[ADDR_W-1:0];

    // ------------------------------------------------------------------
    // Ring-buffer address step
    // ------------------------------------------------------------------
    // One extra bit so that stepping past the last word of a full-size buffer
    // (8*depth == 2^ADDR_W) is still seen as reaching the end.
    logic [ADDR_W:0]   buf_size;
    logic [ADDR_W:0]   in_addr_inc;
    logic [ADDR_W-1:0] in_addr_nxt;
    logic [ADDR_W-1:0] flt_addr_nxt;

    assign buf_size     = {depth_q[ADDR_W-3:0], 3'b000};
    assign in_addr_inc  = {1'b0, bus.in_rd_addr} + (ADDR_W+1)'(8);
    assign in_addr_nxt  = (in_addr_inc >= buf_size) ? ADDR_W'(in_addr_inc - buf_size)
                                                    : ADDR_W'(in_addr_inc);
    assign flt_addr_nxt = bus.flt_rd_addr + ADDR_W'(8);

    // ------------------------------------------------------------------
    // 8-lane multiply-accumulate for the beat currently on the read bus
    // ------------------------------------------------------------------
    // Plain 32-bit unsigned arithmetic on sign-extended operands gives the
    // same low 32 bits as the signed computation, i.e. wrap-around mod 2^32.
    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    logic [31:0] beat_sum;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < 8; i++) begin
            beat_sum = beat_sum
                     + sext8(bus.flt_rd_data[8*i +: 8])
                     * (sext8(bus.in_rd_data[8*i +: 8]) + offset_q);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM; all status and read-port outputs are registered here
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            depth_q         <= '0;
            offset_q        <= '0;
            beat_cnt        <= '0;
            data_vld        <= 1'b0;
            bus.rd_en       <= 1'b0;
            bus.in_rd_addr  <= '0;
            bus.flt_rd_addr <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
            bus.acc         <= '0;
        end else begin
            // the buffers answer one cycle after the strobe
            data_vld <= bus.rd_en;

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        bus.acc <= '0;
                        if (cfg_ok) begin
                            depth_q         <= bus.input_depth;
                            offset_q        <= bus.input_offset;
                            bus.err         <= 1'b0;
                            bus.busy        <= 1'b1;
                            bus.rd_en       <= 1'b1;
                            bus.in_rd_addr  <= base_addr;
                            bus.flt_rd_addr <= '0;
                            beat_cnt        <= 32'd1;
                            state           <= ST_RUN;
                        end else begin
                            // bad configuration: no reads, just report and finish
                            bus.err  <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end

                ST_RUN: begin
                    if (data_vld) begin
                        bus.acc <= bus.acc + beat_sum;
                    end
                    if (bus.abort) begin
                        bus.rd_en       <= 1'b0;
                        bus.busy        <= 1'b0;
                        bus.in_rd_addr  <= '0;
                        bus.flt_rd_addr <= '0;
                        state           <= ST_IDLE;
                    end else if (beat_cnt == depth_q) begin
                        // last beat is on the bus now; its data lands in DRAIN
                        bus.rd_en       <= 1'b0;
                        bus.in_rd_addr  <= '0;
                        bus.flt_rd_addr <= '0;
                        state           <= ST_DRAIN;
                    end else begin
                        bus.in_rd_addr  <= in_addr_nxt;
                        bus.flt_rd_addr <= flt_addr_nxt;
                        beat_cnt        <= beat_cnt + 32'd1;
                    end
                end

                ST_DRAIN: begin
                    if (data_vld) begin
                        bus.acc <= bus.acc + beat_sum;
                    end
                    bus.busy <= 1'b0;
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else begin
                        bus.done <= 1'b1;
                        state    <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    bus.done <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Busy-cycle performance counter
    // ------------------------------------------------------------------
`ifdef CONV1D_SEQ_PERF_CNT_EN
    logic [31:0] busy_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (start_req && cfg_ok) begin
            busy_cnt <= '0;
        end else if (bus.busy && (busy_cnt != 32'hFFFF_FFFF)) begin
            busy_cnt <= busy_cnt + 32'd1;
        end
    end

    assign bus.busy_cycles = busy_cnt;
`else
    assign bus.busy_cycles = '0;
`endif

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Directed self-checking bench for conv1d_sequencer.
// A one-cycle-latency buffer model answers every read strobe.
// Expected values are worked out by hand for each directed step.
module tb_conv1d_sequencer;

    localparam int ADDR_W = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    // observations gathered by watch()
    int          rd_cnt;
    int          done_t;
    int          done_cnt;
    int          addr_bad;
    int          busy_cnt;
    logic [31:0] acc_done;
    logic [31:0] bc_done;
    logic        err_done;
    int          in_q[$];
    int          flt_q[$];

    logic [63:0] in_mem  [128];
    logic [63:0] flt_mem [128];

    int exp_wrap[8];
    int rej_dep[4];
    int rej_sx[4];

    always #5 clk = ~clk;

    conv1d_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    conv1d_sequencer #(
        .ADDR_W    (ADDR_W),
        .MAX_DEPTH (128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // buffers: data for a strobe in cycle n is on the bus during cycle n+1;
    // without a strobe the bus carries junk that must never be accumulated
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.in_rd_data  <= in_mem[bus.in_rd_addr[ADDR_W-1:3]];
            bus.flt_rd_data <= flt_mem[bus.flt_rd_addr[ADDR_W-1:3]];
        end else begin
            bus.in_rd_data  <= 64'hA5C3_0F96_7E11_D24B;
            bus.flt_rd_data <= 64'h3CF0_5A69_81B7_E24D;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] rep8(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic logic [31:0] bc_exp(input int n);
`ifdef CONV1D_SEQ_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] in_b, input logic [7:0] flt_b);
        for (int w = 0; w < 128; w++) begin
            in_mem[w]  = rep8(in_b);
            flt_mem[w] = rep8(flt_b);
        end
    endtask

    // word w of both buffers holds the byte value w+1 (words 0..7)
    task automatic fill_ramp();
        for (int w = 0; w < 8; w++) begin
            in_mem[w]  = rep8(8'(w + 1));
            flt_mem[w] = rep8(8'(w + 1));
        end
    endtask

    // drive a one-cycle start; returns in cycle t=1 (first cycle after the accepting edge)
    task automatic launch(input logic [31:0] sx, input logic [31:0] dep, input logic [31:0] off);
        bus.start_x      = sx;
        bus.input_depth  = dep;
        bus.input_offset = off;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
    endtask

    // observe cycles t0..limit, the current cycle being t0
    task automatic watch(input int t0, input int limit);
        rd_cnt   = 0;
        done_t   = -1;
        done_cnt = 0;
        addr_bad = 0;
        busy_cnt = 0;
        acc_done = 32'hDEAD_BEEF;
        bc_done  = 32'hDEAD_BEEF;
        err_done = 1'bx;
        in_q.delete();
        flt_q.delete();
        for (int t = t0; t <= limit; t++) begin
            if (bus.rd_en) begin
                rd_cnt++;
                in_q.push_back(int'(bus.in_rd_addr));
                flt_q.push_back(int'(bus.flt_rd_addr));
            end else if ((bus.in_rd_addr != '0) || (bus.flt_rd_addr != '0)) begin
                addr_bad++;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_t < 0) begin
                    done_t   = t;
                    acc_done = bus.acc;
                    bc_done  = bus.busy_cycles;
                    err_done = bus.err;
                end
            end
            if (t < limit) tick();
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.start_x      = '0;
        bus.input_depth  = '0;
        bus.input_offset = '0;
        fill(8'h00, 8'h00);
        exp_wrap = '{56, 0, 8, 16, 24, 32, 40, 48};
        rej_dep  = '{12, 0, 136, 8};
        rej_sx   = '{0, 0, 0, 8};

        // ---------------- reset state ----------------
        #1 reset = 1'b1;
        #1;
        check1("rst_rd_en", bus.rd_en, 1'b0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_done", bus.done, 1'b0);
        check1("rst_err", bus.err, 1'b0);
        check("rst_acc", bus.acc, 32'd0);
        check("rst_busy_cycles", bus.busy_cycles, 32'd0);
        check("rst_in_addr", 32'(bus.in_rd_addr), 32'd0);
        check("rst_flt_addr", 32'(bus.flt_rd_addr), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // ---------------- basic run: 8 beats of 8*(2*1) ----------------
        fill(8'h01, 8'h02);
        launch(0, 8, 0);
        watch(1, 14);
        check("basic_rd_beats", rd_cnt, 8);
        check("basic_done_cycle", done_t, 10);
        check("basic_done_pulses", done_cnt, 1);
        check("basic_acc", acc_done, 32'd128);
        check("basic_busy_cycles", bc_done, bc_exp(9));
        check("basic_busy_len", busy_cnt, 9);
        check("basic_idle_addr", addr_bad, 0);
        check("basic_in_first", in_q[0], 0);
        check("basic_in_last", in_q[7], 56);
        check("basic_acc_held", bus.acc, 32'd128);

        // ---------------- input offset ----------------
        fill(8'h80, 8'h7F);
        launch(0, 8, 128);
        watch(1, 12);
        check("offset128_done_cycle", done_t, 10);
        check("offset128_acc", acc_done, 32'd0);
        launch(0, 8, 129);
        watch(1, 12);
        check("offset129_acc", acc_done, 32'd8128);

        // ---------------- ring wrap from start_x=7 ----------------
        fill(8'h00, 8'h00);
        fill_ramp();
        launch(7, 8, 0);
        watch(1, 12);
        check("wrap_rd_beats", rd_cnt, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("wrap_in_addr[%0d]", k), in_q[k], exp_wrap[k]);
            check($sformatf("wrap_flt_addr[%0d]", k), flt_q[k], 8 * k);
        end
        // beat k pairs input word (7+k)%8 with filter word k
        check("wrap_acc", acc_done, 32'd1408);

        // ---------------- rejected configurations ----------------
        for (int i = 0; i < 4; i++) begin
            launch(rej_sx[i], rej_dep[i], 0);
            watch(1, 4);
            check($sformatf("reject%0d_done_cycle", i), done_t, 1);
            check($sformatf("reject%0d_rd_beats", i), rd_cnt, 0);
            check($sformatf("reject%0d_busy", i), busy_cnt, 0);
            check1($sformatf("reject%0d_err", i), err_done, 1'b1);
            check($sformatf("reject%0d_acc", i), acc_done, 32'd0);
        end
        check1("reject_err_sticky", bus.err, 1'b1);

        // valid start clears err; ramp words give 8*(1+4+...+64)
        launch(0, 8, 0);
        check1("restart_err_cleared", bus.err, 1'b0);
        watch(1, 12);
        check("restart_done_cycle", done_t, 10);
        check("restart_acc", acc_done, 32'd1632);

        // ---------------- largest depth, wrapping at the end of the address space ----------------
        fill(8'h01, 8'h01);
        launch(7, 128, 0);
        watch(1, 133);
        check("max_rd_beats", rd_cnt, 128);
        check("max_done_cycle", done_t, 130);
        check("max_in_first", in_q[0], 896);
        check("max_in_top", in_q[15], 1016);
        check("max_in_wrapped", in_q[16], 0);
        check("max_in_last", in_q[127], 888);
        check("max_flt_last", flt_q[127], 1016);
        check("max_acc", acc_done, 32'd1024);
        check("max_busy_cycles", bc_done, bc_exp(129));

        // ---------------- abort in beat 3 of a depth-16 run ----------------
        fill(8'h01, 8'h02);
        launch(0, 16, 0);
        tick();
        tick();
        check1("abort_beat3_rd_en", bus.rd_en, 1'b1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check1("abort_busy", bus.busy, 1'b0);
        check1("abort_rd_en", bus.rd_en, 1'b0);
        check("abort_in_addr", 32'(bus.in_rd_addr), 32'd0);
        check("abort_busy_cycles", bus.busy_cycles, bc_exp(3));
        watch(4, 25);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_reads", rd_cnt, 0);

        // ---------------- start with abort in IDLE is not accepted ----------------
        bus.start_x     = 0;
        bus.input_depth = 8;
        bus.start       = 1'b1;
        bus.abort       = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        check1("startabort_busy", bus.busy, 1'b0);
        watch(1, 12);
        check("startabort_no_reads", rd_cnt, 0);
        check("startabort_no_done", done_cnt, 0);

        // ---------------- start while busy is ignored ----------------
        launch(0, 8, 0);
        check1("busystart_t1_rd_en", bus.rd_en, 1'b1);
        bus.start_x     = 3;
        bus.input_depth = 16;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
        watch(2, 14);
        check("busystart_rd_beats", rd_cnt, 7);
        check("busystart_done_cycle", done_t, 10);
        check("busystart_acc", acc_done, 32'd128);
        check("busystart_last_addr", in_q[6], 56);
        check("busystart_busy_cycles", bc_done, bc_exp(9));

        // ---------------- reset in the middle of a run ----------------
        launch(0, 8, 0);
        tick();
        tick();
        check("midrst_acc_before", bus.acc, 32'd16);
        check("midrst_bc_before", bus.busy_cycles, bc_exp(2));
        reset = 1'b1;
        #1;
        check1("midrst_rd_en", bus.rd_en, 1'b0);
        check1("midrst_busy", bus.busy, 1'b0);
        check1("midrst_done", bus.done, 1'b0);
        check("midrst_acc", bus.acc, 32'd0);
        check("midrst_in_addr", 32'(bus.in_rd_addr), 32'd0);
        check("midrst_flt_addr", 32'(bus.flt_rd_addr), 32'd0);
        check("midrst_busy_cycles", bus.busy_cycles, 32'd0);
        tick();

        // start accepted on the first edge after reset is released
        reset = 1'b0;
        launch(0, 8, 0);
        check1("postrst_rd_en", bus.rd_en, 1'b1);
        check1("postrst_busy", bus.busy, 1'b1);
        watch(1, 12);
        check("postrst_done_cycle", done_t, 10);
        check("postrst_acc", acc_done, 32'd128);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/conv1d_sequencer.md
CONV1D_SEQUENCER -- requirements
Module: conv1d_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width of the input and filter buffers (1024 entries).
REQ-002 SHALL have parameter MAX_DEPTH, default 128, largest accepted input_depth.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, on the ports below:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- start  in  1  single-cycle request to begin one accumulation
- abort  in  1  single-cycle request to cancel a run
- start_x  in  32  ring-buffer start position, 0..7
- input_depth  in  32  channel count; buffer size = 8*input_depth
- input_offset  in  32  signed offset added to every input byte
- rd_en  out  1  buffer read strobe
- in_rd_addr  out  ADDR_W  input-buffer byte address, 8-aligned
- flt_rd_addr  out  ADDR_W  filter-buffer byte address, 8-aligned
- in_rd_data  in  64  8 signed input bytes; byte i = bits [8i+7:8i]
- flt_rd_data  in  64  8 signed filter bytes, same packing
- busy  out  1  run in progress
- done  out  1  single-cycle completion pulse
- err  out  1  last start was rejected
- acc  out  32  signed accumulator
- busy_cycles  out  32  performance counter (REQ-021)

Function
REQ-004 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-005 SHALL accept start only in IDLE; a start in any other state is ignored.
REQ-006 SHALL treat start and abort asserted together in IDLE as abort, so the start is not accepted.
REQ-007 SHALL, on an accepted start, latch start_x, input_depth and input_offset, clear acc to 0, clear err, and enter RUN on the next cycle.
REQ-008 SHALL reject a start when input_depth==0, input_depth%8!=0, input_depth>MAX_DEPTH or start_x>7: set err=1, leave acc=0, never assert rd_en, go IDLE->DONE->IDLE, and pulse done one cycle after start.
REQ-009 SHALL, in RUN, assert rd_en for exactly input_depth consecutive cycles (beats), then enter DRAIN for one cycle, then DONE for one cycle, then IDLE.
REQ-010 SHALL address beats as follows:
- flt_rd_addr starts at 0 and adds 8 per beat.
- in_rd_addr starts at start_x*input_depth and adds 8 per beat; when the new value is >= 8*input_depth it SHALL subtract 8*input_depth (ring wrap).
REQ-011 SHALL treat buffer read latency as exactly 1 cycle: data for a beat issued in cycle n is sampled in cycle n+1.
REQ-012 SHALL, per sampled beat, add acc += sum over i=0..7 of flt_i*(in_i+input_offset), with bytes sign-extended to 32 bits and all arithmetic modulo 2^32 (wrap, no saturation).
REQ-013 SHALL have latency start->done of input_depth+2 cycles, with acc final and stable in the done cycle.
REQ-014 SHALL hold acc until the next accepted start.
REQ-015 SHALL keep busy high in RUN and DRAIN only, and done high in DONE only.
REQ-016 SHALL, on abort in RUN or DRAIN, deassert rd_en and busy next cycle, return to IDLE, produce no done pulse, and leave acc holding a partial, undefined-for-use value.
REQ-017 SHALL drive in_rd_addr and flt_rd_addr to 0 whenever rd_en=0.

Reset
REQ-018 SHALL on reset, at any time including mid-run, force state=IDLE and rd_en=busy=done=err=0.
REQ-019 SHALL on reset set acc=0, busy_cycles=0, in_rd_addr=flt_rd_addr=0, and all latched parameters to 0.
REQ-020 SHALL accept a start on the first clock edge after reset deasserts.

Configuration
REQ-021 SHALL, when macro CONV1D_SEQ_PERF_CNT_EN is defined:
- increment busy_cycles every cycle busy=1;
- clear busy_cycles on an accepted start;
- saturate busy_cycles at 2^32-1.
REQ-022 SHALL, when CONV1D_SEQ_PERF_CNT_EN is undefined, keep the busy_cycles port present but tied to constant 0, with no counter logic.

Verification
REQ-023 SHALL test a basic run: depth=8, start_x=0, offset=0, all input bytes 1, all filter bytes 2 -> rd_en for 8 cycles, done at start+10, acc=128, busy_cycles=9 (macro on).
REQ-024 SHALL test the offset: depth=8, inputs -128, offset=128, filters 127 -> acc=0; with offset=129 -> acc=64*127=8128.
REQ-025 SHALL test ring wrap: depth=8, start_x=7 -> in_rd_addr sequence 56,0,8,16,24,32,40,48 and flt_rd_addr sequence 0..56 step 8.
REQ-026 SHALL test rejection: depth=12 -> err=1, done at start+1, rd_en never high, acc=0; a following valid start clears err.
REQ-027 SHALL test abort and reset:
- abort in beat 3 of a depth=16 run -> busy=0 next cycle, no done.
- reset mid-run -> all outputs 0 immediately (asynchronously).
- start while busy -> ignored, latency unchanged.
